// File: rtl/prpg_sig_analyzer.sv
// MISR signature compactor for the PRPG pattern stream, with Hamming-distance
// statistics and a golden-signature compare at the end of a programmed run.
module prpg_sig_analyzer #(
   parameter int unsigned NPAT_W  = 8,
   parameter int unsigned HDSUM_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [6:0]         cfg_tap,
   input  logic [0:7]         cfg_seed,
   input  logic [NPAT_W-1:0]  cfg_npat,
   input  logic [0:7]         cfg_golden,
   input  logic               pat_valid,
   output logic               pat_ready,
   input  logic [0:7]         P,
   input  logic [0:7]         P_next,
   output logic [0:7]         sig,
   output logic [HDSUM_W-1:0] hd_sum,
   output logic [3:0]         hd_max,
   output logic [NPAT_W-1:0]  pat_cnt,
   output logic               busy,
   output logic               done,
   output logic               pass
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [6:0]          tap_q, tap_d;
   logic [NPAT_W-1:0]   npat_q, npat_d;
   logic [0:7]          golden_q, golden_d;
   logic [0:7]          sig_q, sig_d;
   logic [HDSUM_W-1:0]  hd_sum_q, hd_sum_d;
   logic [3:0]          hd_max_q, hd_max_d;
   logic [NPAT_W-1:0]   pat_cnt_q, pat_cnt_d;
   logic                pass_q, pass_d;

   logic [0:7]          misr_next;
   logic [0:7]          diff;
   logic [3:0]          h;
   logic [HDSUM_W:0]    hd_add;
   logic [HDSUM_W-1:0]  hd_sum_sat;
   logic [NPAT_W-1:0]   pat_inc;

   // Datapath terms for a transfer; all MISR terms use the pre-update signature.
   always_comb begin
      misr_next    = '0;
      misr_next[0] = sig_q[7] ^ P[0];
      for (int unsigned k = 1; k < 8; k++) begin
         misr_next[k] = sig_q[k-1] ^ P[k] ^ (tap_q[7-k] & sig_q[7]);
      end
      diff = P ^ P_next;
      h    = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         h = h + {3'b000, diff[i]};
      end
      hd_add     = {1'b0, hd_sum_q} + {{(HDSUM_W-3){1'b0}}, h};
      hd_sum_sat = hd_add[HDSUM_W] ? '1 : hd_add[HDSUM_W-1:0];
      pat_inc    = pat_cnt_q + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      npat_d    = npat_q;
      golden_d  = golden_q;
      sig_d     = sig_q;
      hd_sum_d  = hd_sum_q;
      hd_max_d  = hd_max_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               tap_d     = cfg_tap;
               npat_d    = cfg_npat;
               golden_d  = cfg_golden;
               sig_d     = cfg_seed;
               hd_sum_d  = '0;
               hd_max_d  = '0;
               pat_cnt_d = '0;
               pass_d    = 1'b0;
               if (cfg_npat == '0) begin
                  state_d = S_DONE;
                  pass_d  = (cfg_seed == cfg_golden);
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (pat_valid) begin
               sig_d     = misr_next;
               hd_sum_d  = hd_sum_sat;
               hd_max_d  = (h > hd_max_q) ? h : hd_max_q;
               pat_cnt_d = pat_inc;
               if (pat_inc == npat_q) begin
                  state_d = S_DONE;
                  pass_d  = (misr_next == golden_q);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tap_q     <= '0;
         npat_q    <= '0;
         golden_q  <= '0;
         sig_q     <= '0;
         hd_sum_q  <= '0;
         hd_max_q  <= '0;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tap_q     <= tap_d;
         npat_q    <= npat_d;
         golden_q  <= golden_d;
         sig_q     <= sig_d;
         hd_sum_q  <= hd_sum_d;
         hd_max_q  <= hd_max_d;
         pat_cnt_q <= pat_cnt_d;
         pass_q    <= pass_d;
      end
   end

   assign pat_ready = (state_q == S_COLLECT);
   assign busy      = (state_q == S_COLLECT);
   assign done      = (state_q == S_DONE);
   assign sig       = sig_q;
   assign hd_sum    = hd_sum_q;
   assign hd_max    = hd_max_q;
   assign pat_cnt   = pat_cnt_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_prpg_sig_analyzer.sv
// Directed bench for prpg_sig_analyzer; a second instance with a 4-bit
// accumulator exercises hd_sum saturation.
module tb_prpg_sig_analyzer;

   logic        clk = 1'b0;
   logic        rst, start, pat_valid;
   logic [6:0]  cfg_tap;
   logic [0:7]  cfg_seed, cfg_golden, P, P_next;
   logic [7:0]  cfg_npat;

   logic        pat_ready, busy, done, pass;
   logic [0:7]  sig;
   logic [15:0] hd_sum;
   logic [3:0]  hd_max;
   logic [7:0]  pat_cnt;

   logic        s_pat_ready, s_busy, s_done, s_pass;
   logic [0:7]  s_sig;
   logic [3:0]  s_hd_sum;
   logic [3:0]  s_hd_max;
   logic [7:0]  s_pat_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prpg_sig_analyzer #(.NPAT_W(8), .HDSUM_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
      .cfg_npat(cfg_npat), .cfg_golden(cfg_golden), .pat_valid(pat_valid),
      .pat_ready(pat_ready), .P(P), .P_next(P_next), .sig(sig), .hd_sum(hd_sum),
      .hd_max(hd_max), .pat_cnt(pat_cnt), .busy(busy), .done(done), .pass(pass)
   );

   prpg_sig_analyzer #(.NPAT_W(8), .HDSUM_W(4)) u_sat (
      .clk(clk), .rst(rst), .start(start), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
      .cfg_npat(cfg_npat), .cfg_golden(cfg_golden), .pat_valid(pat_valid),
      .pat_ready(s_pat_ready), .P(P), .P_next(P_next), .sig(s_sig), .hd_sum(s_hd_sum),
      .hd_max(s_hd_max), .pat_cnt(s_pat_cnt), .busy(s_busy), .done(s_done), .pass(s_pass)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input logic [6:0] tap, input logic [0:7] seed,
                            input logic [7:0] npat, input logic [0:7] golden);
      cfg_tap = tap; cfg_seed = seed; cfg_npat = npat; cfg_golden = golden;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(input logic [0:7] p, input logic [0:7] pn);
      P = p; P_next = pn; pat_valid = 1'b1;
      tick();
      pat_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({sig, hd_sum, hd_max, pat_cnt, pass, done, pat_ready, busy} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_state: sig=%b hd_sum=%0d hd_max=%0d cnt=%0d pass=%b done=%b rdy=%b busy=%b, all required 0",
                  sig, hd_sum, hd_max, pat_cnt, pass, done, pat_ready, busy);
      end
   endtask

   task automatic test_single();
      begin_run(7'b0000000, 8'b00000000, 8'd1, 8'b10000000);
      vectors++;
      if (busy !== 1'b1 || pat_ready !== 1'b1 || sig !== 8'b00000000) begin
         miscompares++;
         $display("FAIL single_collect: busy=%b rdy=%b sig=%b, required 1 1 00000000", busy, pat_ready, sig);
      end
      xfer(8'b10000000, 8'b10000000);
      vectors++;
      if (sig !== 8'b10000000 || hd_sum !== 16'd0 || hd_max !== 4'd0) begin
         miscompares++;
         $display("FAIL single_sig: sig=%b hd_sum=%0d hd_max=%0d, required 10000000 0 0", sig, hd_sum, hd_max);
      end
      vectors++;
      if (done !== 1'b1 || pass !== 1'b1 || pat_cnt !== 8'd1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: done=%b pass=%b cnt=%0d busy=%b, required 1 1 1 0", done, pass, pat_cnt, busy);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || pass !== 1'b1 || sig !== 8'b10000000) begin
         miscompares++;
         $display("FAIL single_hold: done=%b pass=%b sig=%b, required 0 1 10000000", done, pass, sig);
      end
   endtask

   task automatic test_tap();
      begin_run(7'b0100101, 8'b00000001, 8'd1, 8'b00000000);
      xfer(8'b00000000, 8'b11111111);
      vectors++;
      if (sig !== 8'b10100101 || hd_sum !== 16'd8 || hd_max !== 4'd8) begin
         miscompares++;
         $display("FAIL tap_feedback: sig=%b hd_sum=%0d hd_max=%0d, required 10100101 8 8", sig, hd_sum, hd_max);
      end
      vectors++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         miscompares++;
         $display("FAIL tap_pass: done=%b pass=%b, required 1 0", done, pass);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [0:7] pv [3];
      logic [0:7] pn [3];
      int dones = 0;
      pv[0] = 8'b11000000; pn[0] = 8'b00000000;
      pv[1] = 8'b00000000; pn[1] = 8'b11111000;
      pv[2] = 8'b00000001; pn[2] = 8'b00000111;
      begin_run(7'b0000000, 8'b00000000, 8'd3, 8'b00110001);
      for (int t = 0; t < 3; t++) begin
         xfer(pv[t], pn[t]);
         if (done === 1'b1) dones++;
         vectors++;
         if (pat_cnt !== 8'(t + 1)) begin
            miscompares++;
            $display("FAIL stall_cnt: transfer %0d cnt=%0d, required %0d", t, pat_cnt, t + 1);
         end
         if (t < 2) begin
            for (int s = 0; s < 5; s++) begin
               tick();
               if (done === 1'b1) dones++;
            end
            vectors++;
            if (pat_cnt !== 8'(t + 1) || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL stall_hold: after stall %0d cnt=%0d busy=%b, required %0d 1", t, pat_cnt, busy, t + 1);
            end
         end
      end
      vectors++;
      if (done !== 1'b1 || sig !== 8'b00110001 || hd_sum !== 16'd9 || hd_max !== 4'd5 || pass !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_final: done=%b sig=%b hd_sum=%0d hd_max=%0d pass=%b, required 1 00110001 9 5 1",
                  done, sig, hd_sum, hd_max, pass);
      end
      tick();
      if (done === 1'b1) dones++;
      xfer(8'b11111111, 8'b00000000);
      if (done === 1'b1) dones++;
      tick();
      if (done === 1'b1) dones++;
      vectors++;
      if (dones !== 1) begin
         miscompares++;
         $display("FAIL stall_done_count: done pulses=%0d, required 1", dones);
      end
      vectors++;
      if (pat_cnt !== 8'd3 || sig !== 8'b00110001 || hd_sum !== 16'd9 || hd_max !== 4'd5 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_valid: cnt=%0d sig=%b hd_sum=%0d hd_max=%0d busy=%b, required 3 00110001 9 5 0",
                  pat_cnt, sig, hd_sum, hd_max, busy);
      end
   endtask

   task automatic test_zero();
      logic [0:7] gold [2];
      gold[0] = 8'b01011010;
      gold[1] = 8'b01011011;
      for (int r = 0; r < 2; r++) begin
         begin_run(7'b1111111, 8'b01011010, 8'd0, gold[r]);
         vectors++;
         if (done !== 1'b1 || pass !== (r == 0) || pat_ready !== 1'b0 || sig !== 8'b01011010) begin
            miscompares++;
            $display("FAIL zero_npat: run %0d done=%b pass=%b rdy=%b sig=%b, required 1 %0d 0 01011010",
                     r, done, pass, pat_ready, sig, r == 0);
         end
         tick();
         vectors++;
         if (done !== 1'b0 || pass !== (r == 0) || pat_ready !== 1'b0 || pat_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL zero_after: run %0d done=%b pass=%b rdy=%b cnt=%0d, required 0 %0d 0 0",
                     r, done, pass, pat_ready, pat_cnt, r == 0);
         end
      end
   endtask

   task automatic test_reset_mid();
      begin_run(7'b0000000, 8'b00000000, 8'd4, 8'b00000000);
      xfer(8'b11110000, 8'b00000000);
      // start while collecting must neither restart nor re-latch
      cfg_npat = 8'd0; cfg_seed = 8'b11111111;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || pat_cnt !== 8'd1 || sig !== 8'b11110000 || hd_sum !== 16'd4) begin
         miscompares++;
         $display("FAIL start_ignored: busy=%b cnt=%0d sig=%b hd_sum=%0d, required 1 1 11110000 4",
                  busy, pat_cnt, sig, hd_sum);
      end
      xfer(8'b00000000, 8'b00000000);
      rst = 1'b1; pat_valid = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; pat_valid = 1'b0; start = 1'b0;
      vectors++;
      if ({sig, hd_sum, hd_max, pat_cnt, pass, done, pat_ready, busy} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_mid: sig=%b hd_sum=%0d hd_max=%0d cnt=%0d pass=%b done=%b rdy=%b busy=%b, all required 0",
                  sig, hd_sum, hd_max, pat_cnt, pass, done, pat_ready, busy);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_done: done=%b busy=%b, required 0 0", done, busy);
      end
      begin_run(7'b0000000, 8'b00000000, 8'd1, 8'b10000000);
      xfer(8'b10000000, 8'b01000000);
      vectors++;
      if (done !== 1'b1 || pass !== 1'b1 || sig !== 8'b10000000 || hd_sum !== 16'd2 || hd_max !== 4'd2) begin
         miscompares++;
         $display("FAIL reset_fresh: done=%b pass=%b sig=%b hd_sum=%0d hd_max=%0d, required 1 1 10000000 2 2",
                  done, pass, sig, hd_sum, hd_max);
      end
      tick();
   endtask

   task automatic test_saturation();
      logic [3:0] exp_sum [3];
      exp_sum[0] = 4'd8; exp_sum[1] = 4'd15; exp_sum[2] = 4'd15;
      begin_run(7'b0000000, 8'b00000000, 8'd3, 8'b00000000);
      for (int t = 0; t < 3; t++) begin
         xfer(8'b00000000, 8'b11111111);
         vectors++;
         if (s_hd_sum !== exp_sum[t] || s_hd_max !== 4'd8) begin
            miscompares++;
            $display("FAIL hd_saturate: transfer %0d hd_sum=%0d hd_max=%0d, required %0d 8",
                     t, s_hd_sum, s_hd_max, exp_sum[t]);
         end
      end
      vectors++;
      if (hd_sum !== 16'd24 || s_done !== 1'b1) begin
         miscompares++;
         $display("FAIL hd_wide: hd_sum=%0d sat_done=%b, required 24 1", hd_sum, s_done);
      end
      tick();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; pat_valid = 1'b0;
      cfg_tap = '0; cfg_seed = '0; cfg_npat = '0; cfg_golden = '0;
      P = '0; P_next = '0;
      tick();
      test_reset();
      test_single();
      test_tap();
      test_stall();
      test_zero();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prpg_sig_analyzer.md
Name: prpg_sig_analyzer

Overview:
- Downstream consumer of the LFSR PRPG stage.
- Takes the generated pattern stream (P and P_next) and compacts it into an 8-bit MISR signature using the same 7-bit tap convention as the generator.
- Accumulates Hamming-distance (transition) statistics per pattern.
- After a programmed number of patterns, compares the signature against a golden value and reports pass/fail to the test controller.

Parameters:
- NPAT_W, 8, width of the pattern-count field.
- HDSUM_W, 16, width of the saturating Hamming-distance accumulator.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches config and begins a run (accepted only in IDLE).
- cfg_tap  in  7  MISR feedback taps; bit ordering as the generator's config_L field.
- cfg_seed  in  [0:7]  initial signature value.
- cfg_npat  in  NPAT_W  number of patterns to compact; 0 means complete immediately.
- cfg_golden  in  [0:7]  expected final signature.
- pat_valid  in  1  P/P_next are valid this cycle.
- pat_ready  out  1  high in COLLECT only; a transfer occurs when pat_valid && pat_ready.
- P  in  [0:7]  current pattern.
- P_next  in  [0:7]  next pattern.
- sig  out  [0:7]  running/final signature.
- hd_sum  out  HDSUM_W  sum of popcount(P^P_next) over accepted patterns; saturates at all-ones.
- hd_max  out  4  maximum per-pattern Hamming distance seen (0..8).
- pat_cnt  out  NPAT_W  patterns accepted this run.
- busy  out  1  high in COLLECT.
- done  out  1  single-cycle pulse on entry to DONE.
- pass  out  1  (sig == cfg_golden latched); valid from the done cycle until the next start or reset.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - sig=0, hd_sum=0, hd_max=0, pat_cnt=0, pass=0, done=0, pat_ready=0, busy=0.
  - Latched config is cleared to 0.
  - Reset mid-COLLECT aborts the run with no done pulse.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 latches tap/seed/npat/golden.
  - Sets sig=cfg_seed and clears hd_sum, hd_max and pat_cnt.
  - Next state: COLLECT if cfg_npat!=0, else DONE.
- COLLECT, on each transfer (pat_valid && pat_ready), with D=P and S=sig:
  - MISR update, all terms from pre-update S:
    - S'[0] = S[7] ^ D[0]
    - S'[k] = S[k-1] ^ D[k] ^ (tap[7-k] & S[7]), for k=1..7
  - h = popcount(P ^ P_next), 0..8.
  - hd_sum += h, saturating at 2^HDSUM_W-1.
  - hd_max = max(hd_max, h).
  - pat_cnt += 1.
  - When the transfer makes pat_cnt == npat, next state is DONE.
  - No transfer means no state change; a stall of any length is allowed.
- DONE:
  - done=1 for exactly the entry cycle.
  - pass = (sig == golden), registered at entry.
  - Outputs hold.
  - Next state: IDLE on the following cycle; outputs keep holding until the next start.
- start is ignored in COLLECT and DONE; it does not restart or re-latch config.
- pat_valid is ignored outside COLLECT; no state change.
- Latency:
  - sig, hd_sum, hd_max and pat_cnt reflect a transfer on the next posedge (one-cycle latency).
  - done asserts the cycle after the final transfer.
  - With npat=0, done asserts the cycle after start; pass=(seed==golden).
- pat_cnt does not wrap: the maximum npat is 2^NPAT_W-1, and the run ends at equality.
- tap=0: the signature is a pure rotate-with-XOR of the data.
- rst has priority over start and pat_valid in the same cycle.

Test Plan:
- Single pattern, plain compaction:
  - Stimulus: reset; start with seed=00000000, tap=0, npat=1, golden=10000000; one transfer with P=10000000, P_next=10000000.
  - Required: sig=10000000, hd_sum=0, hd_max=0, done pulse, pass=1.
- Tap feedback only:
  - Stimulus: seed=00000001, tap=0100101, npat=1; transfer with P=00000000, P_next=11111111.
  - Required: sig=10100101, hd_sum=8, hd_max=8.
- Stall and stray input:
  - Stimulus: npat=3; pat_valid pulsed with 5 idle cycles between transfers; an extra pat_valid after done.
  - Required:
    - pat_cnt counts 1, 2, 3.
    - done exactly once, one cycle after the third transfer.
    - The extra pat_valid is ignored; outputs are unchanged.
- Zero patterns:
  - Stimulus: npat=0, seed=golden=01011010.
  - Required: done the cycle after start, pass=1, pat_ready never high.
  - Repeat with golden=01011011: pass=0.
- Reset mid-run:
  - Stimulus: rst asserted after 2 of 4 transfers.
  - Required: next cycle state=IDLE, all outputs 0, no done pulse; a fresh start then runs normally.
- hd_sum saturation:
  - Stimulus: HDSUM_W=4, npat=3, each pattern with HD=8.
  - Required: hd_sum=8, then 15, then 15 (saturated); hd_max=8.
